// File: rtl/dcache_if.sv
// dcache_if: CPU request/ack and memory request/fill bus of dcache_param.
// Ports (signals):
//   req_valid/req_retry, req_addr, req_data, req_op, req_rd : CPU request
//   ack_valid/ack_retry, ack_data, ack_rd                   : load response
//   mem_req_valid/mem_req_retry, mem_req_we/addr/data/size  : memory request
//   mem_ack_valid, mem_ack_data                             : line fill return
// Modports: master = CPU + memory side, slave = cache.
interface dcache_if #(
    parameter int ADDR_W     = 64,
    parameter int LINE_BYTES = 32
);
    logic                    req_valid;
    logic                    req_retry;
    logic [ADDR_W-1:0]       req_addr;
    logic [63:0]             req_data;
    logic [3:0]              req_op;
    logic [4:0]              req_rd;
    logic                    ack_valid;
    logic                    ack_retry;
    logic [63:0]             ack_data;
    logic [4:0]              ack_rd;
    logic                    mem_req_valid;
    logic                    mem_req_retry;
    logic                    mem_req_we;
    logic [ADDR_W-1:0]       mem_req_addr;
    logic [63:0]             mem_req_data;
    logic [1:0]              mem_req_size;
    logic                    mem_ack_valid;
    logic [8*LINE_BYTES-1:0] mem_ack_data;

    modport master (
        output req_valid, req_addr, req_data, req_op, req_rd, ack_retry,
               mem_req_retry, mem_ack_valid, mem_ack_data,
        input  req_retry, ack_valid, ack_data, ack_rd,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_data, mem_req_size
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_op, req_rd, ack_retry,
               mem_req_retry, mem_ack_valid, mem_ack_data,
        output req_retry, ack_valid, ack_data, ack_rd,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_data, mem_req_size
    );
endinterface

// File: rtl/dcache_param.sv
// dcache_param: parameterised direct-mapped, write-through, no-write-allocate,
// blocking data cache.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : dcache_if.slave (CPU request/ack, memory request/fill)
//   stat_hits / stat_misses : saturating load hit/miss counters, present only
//                             when DCACHE_STATS_EN is defined
module dcache_param #(
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 32,
    parameter int ADDR_W     = 64
) (
    input  logic        clk,
    input  logic        reset,
    dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int LW    = 8 * LINE_BYTES;

    typedef enum logic [2:0] {INIT, IDLE, FILL_REQ, FILL_WAIT, STORE_REQ, RESP} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_q, clr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [2:0]        rop_q, rop_d;
    logic [63:0]       ack_data_q, ack_data_d;
    logic [4:0]        ack_rd_q, ack_rd_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [63:0]       mem_data_q, mem_data_d;
    logic [1:0]        mem_size_q, mem_size_d;

    logic [LW-1:0]     line_q [SETS];
    logic [TAG_W-1:0]  tag_q [SETS];
    logic [SETS-1:0]   valid_q;

    logic [OFF_W-1:0]  off, roff;
    logic [IDX_W-1:0]  idx, ridx;
    logic [TAG_W-1:0]  tag, rtag;
    logic              accept, hit, mis, fill_we, store_we;
    logic [2:0]        low_mask;
    logic [63:0]       size_mask;
    logic [LW-1:0]     wmask, wdata;

    assign off  = bus.req_addr[OFF_W-1:0];
    assign idx  = bus.req_addr[OFF_W +: IDX_W];
    assign tag  = bus.req_addr[ADDR_W-1 -: TAG_W];
    assign roff = raddr_q[OFF_W-1:0];
    assign ridx = raddr_q[OFF_W +: IDX_W];
    assign rtag = raddr_q[ADDR_W-1 -: TAG_W];

    assign bus.ack_valid     = state_q == RESP;
    assign bus.req_retry     = !(state_q == IDLE && !bus.ack_valid);
    assign bus.ack_data      = ack_data_q;
    assign bus.ack_rd        = ack_rd_q;
    assign bus.mem_req_valid = state_q == FILL_REQ || state_q == STORE_REQ;
    assign bus.mem_req_we    = mem_we_q;
    assign bus.mem_req_addr  = mem_addr_q;
    assign bus.mem_req_data  = mem_data_q;
    assign bus.mem_req_size  = mem_size_q;

    assign accept    = bus.req_valid && !bus.req_retry;
    assign hit       = valid_q[idx] && tag_q[idx] == tag;
    assign low_mask  = bus.req_op[1:0] == 2'd0 ? 3'd0 : bus.req_op[1:0] == 2'd1 ? 3'd1 :
                       bus.req_op[1:0] == 2'd2 ? 3'd3 : 3'd7;
    assign mis       = |(bus.req_addr[2:0] & low_mask);
    assign size_mask = bus.req_op[1:0] == 2'd0 ? 64'hFF : bus.req_op[1:0] == 2'd1 ? 64'hFFFF :
                       bus.req_op[1:0] == 2'd2 ? 64'hFFFF_FFFF : '1;
    // Store bytes placed at their byte offset within the line for the hit merge.
    assign wmask     = LW'(size_mask) << {off, 3'b000};
    assign wdata     = LW'(bus.req_data & size_mask) << {off, 3'b000};
    // Reset wins over a coincident fill or store so nothing in flight lands.
    assign fill_we   = state_q == FILL_WAIT && bus.mem_ack_valid && !reset;
    assign store_we  = accept && bus.req_op[3] && !mis && hit && !reset;

    // Aligned access: shifting by the byte offset brings the datum to bit 0.
    function automatic logic [63:0] extract(input logic [LW-1:0] line,
                                            input logic [OFF_W-1:0] o,
                                            input logic [2:0] op);
        logic [63:0] w;
        w = 64'(line >> {o, 3'b000});
        return op[1:0] == 2'd0 ? {{56{~op[2] & w[7]}}, w[7:0]} :
               op[1:0] == 2'd1 ? {{48{~op[2] & w[15]}}, w[15:0]} :
               op[1:0] == 2'd2 ? {{32{~op[2] & w[31]}}, w[31:0]} : w;
    endfunction

    always_comb begin
        state_d    = state_q;
        clr_d      = clr_q;
        raddr_d    = raddr_q;
        rop_d      = rop_q;
        ack_data_d = ack_data_q;
        ack_rd_d   = ack_rd_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_size_d = mem_size_q;
        case (state_q)
            INIT: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == IDX_W'(SETS - 1)) state_d = IDLE;
            end
            IDLE: if (accept) begin
                raddr_d = bus.req_addr;
                rop_d   = bus.req_op[2:0];
                if (!bus.req_op[3]) begin
                    ack_rd_d = bus.req_rd;
                    if (mis) begin
                        ack_data_d = 64'hDEADDEAD_DEADDEAD;
                        state_d    = RESP;
                    end else if (hit) begin
                        ack_data_d = extract(line_q[idx], off, bus.req_op[2:0]);
                        state_d    = RESP;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        state_d    = FILL_REQ;
                    end
                end else if (!mis) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = bus.req_addr;
                    mem_data_d = bus.req_data;
                    mem_size_d = bus.req_op[1:0];
                    state_d    = STORE_REQ;
                end
            end
            FILL_REQ:  if (!bus.mem_req_retry) state_d = FILL_WAIT;
            FILL_WAIT: if (bus.mem_ack_valid) begin
                ack_data_d = extract(bus.mem_ack_data, roff, rop_q);
                state_d    = RESP;
            end
            STORE_REQ: if (!bus.mem_req_retry) state_d = IDLE;
            RESP:      if (!bus.ack_retry) state_d = IDLE;
            default:   state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            clr_q      <= '0;
            raddr_q    <= '0;
            rop_q      <= '0;
            ack_data_q <= '0;
            ack_rd_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_size_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            raddr_q    <= raddr_d;
            rop_q      <= rop_d;
            ack_data_q <= ack_data_d;
            ack_rd_q   <= ack_rd_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_size_q <= mem_size_d;
        end
    end

    // Storage arrays: valid bits are cleared by the INIT sweep, not by reset.
    always_ff @(posedge clk) begin
        if (state_q == INIT) valid_q[clr_q] <= 1'b0;
        if (fill_we) begin
            line_q[ridx]  <= bus.mem_ack_data;
            tag_q[ridx]   <= rtag;
            valid_q[ridx] <= 1'b1;
        end
        if (store_we) line_q[idx] <= (line_q[idx] & ~wmask) | (wdata & wmask);
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_q, misses_q;
    logic        count_load;

    assign count_load  = accept && !bus.req_op[3] && !mis;
    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (count_load) begin
            hits_q   <= (hit && hits_q != '1) ? hits_q + 32'd1 : hits_q;
            misses_q <= (!hit && misses_q != '1) ? misses_q + 32'd1 : misses_q;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_param.sv
// tb_dcache_param: directed self-checking bench for dcache_param (SETS=64, 32-byte lines).
module tb_dcache_param;
    localparam int SETS = 64;
    localparam int LB   = 32;
    localparam int AW   = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dcache_if #(.ADDR_W(AW), .LINE_BYTES(LB)) bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    dcache_param #(.SETS(SETS), .LINE_BYTES(LB), .ADDR_W(AW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits(stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [255:0] line0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h89AB_CDEF_FEDC_BA98, 64'h1122_3344_5566_7788};
    logic [255:0] line2 = {64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666,
                           64'h5555_5555_5555_5555, 64'h0BAD_F00D_1234_5678};

    // Drives one request from posedge+1 until accepted; returns at posedge+1 after acceptance.
    task automatic issue(input logic [63:0] a, input logic [63:0] d, input logic [3:0] op,
                         input logic [4:0] rd, output bit ok);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_op    = op;
        bus.req_rd    = rd;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = !bus.req_retry;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset;
        int cnt;
        bus.req_valid = 0; bus.req_addr = 0; bus.req_data = 0; bus.req_op = 0; bus.req_rd = 0;
        bus.ack_retry = 0; bus.mem_req_retry = 0; bus.mem_ack_valid = 0; bus.mem_ack_data = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.req_retry !== 1'b1) begin n_bad++; $display("FAIL rst_retry got=%b exp=1", bus.req_retry); end
        n_cmp++; if (bus.ack_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ack_valid got=%b exp=0", bus.ack_valid); end
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mem_valid got=%b exp=0", bus.mem_req_valid); end
        n_cmp++; if (bus.ack_data !== 64'h0) begin n_bad++; $display("FAIL rst_ack_data got=%h exp=0", bus.ack_data); end
        n_cmp++; if (bus.mem_req_addr !== 64'h0) begin n_bad++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_req_addr); end
        @(posedge clk);
        #1 reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.req_retry) break;
            cnt++;
        end
        n_cmp++; if (cnt !== 64) begin n_bad++; $display("FAIL init_retry_cycles got=%0d exp=64", cnt); end
        n_cmp++; if (bus.req_retry !== 1'b0) begin n_bad++; $display("FAIL init_done_retry got=%b exp=0", bus.req_retry); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill;
        bit ok;
        issue(64'h1000, 64'h0, 4'b0011, 5'd7, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL fill_accept got=%b exp=1", ok); end
        @(negedge clk);
        n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL fill_mem_valid got=%b exp=1", bus.mem_req_valid); end
        n_cmp++; if (bus.mem_req_we !== 1'b0) begin n_bad++; $display("FAIL fill_mem_we got=%b exp=0", bus.mem_req_we); end
        n_cmp++; if (bus.mem_req_addr !== 64'h1000) begin n_bad++; $display("FAIL fill_mem_addr got=%h exp=1000", bus.mem_req_addr); end
        n_cmp++; if (bus.ack_valid !== 1'b0) begin n_bad++; $display("FAIL fill_early_ack got=%b exp=0", bus.ack_valid); end
        @(posedge clk);
        #1 bus.mem_ack_valid = 1'b1; bus.mem_ack_data = line0;
        @(posedge clk);
        #1 bus.mem_ack_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.ack_valid !== 1'b1) begin n_bad++; $display("FAIL fill_ack_valid got=%b exp=1", bus.ack_valid); end
        n_cmp++; if (bus.ack_data !== 64'h1122334455667788) begin n_bad++; $display("FAIL fill_ack_data got=%h exp=1122334455667788", bus.ack_data); end
        n_cmp++; if (bus.ack_rd !== 5'd7) begin n_bad++; $display("FAIL fill_ack_rd got=%0d exp=7", bus.ack_rd); end
        @(posedge clk);
        #1;
        issue(64'h1000, 64'h0, 4'b0011, 5'd9, ok);
        @(negedge clk);
        n_cmp++; if (bus.ack_valid !== 1'b1) begin n_bad++; $display("FAIL hit_ack_valid got=%b exp=1", bus.ack_valid); end
        n_cmp++; if (bus.ack_data !== 64'h1122334455667788) begin n_bad++; $display("FAIL hit_ack_data got=%h exp=1122334455667788", bus.ack_data); end
        n_cmp++; if (bus.ack_rd !== 5'd9) begin n_bad++; $display("FAIL hit_ack_rd got=%0d exp=9", bus.ack_rd); end
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL hit_no_mem got=%b exp=0", bus.mem_req_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_extend;
        bit ok;
        logic [63:0] ta [9];
        logic [3:0]  to [9];
        logic [63:0] te [9];
        ta = '{64'h1007, 64'h1007, 64'h1000, 64'h1000, 64'h1008, 64'h1008, 64'h100C, 64'h100C, 64'h1008};
        to = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0110, 4'b0011};
        te = '{64'h11, 64'h11, 64'hFFFFFFFFFFFFFF88, 64'h88, 64'hFFFFFFFFFFFFBA98, 64'hBA98,
               64'hFFFFFFFF89ABCDEF, 64'h89ABCDEF, 64'h89ABCDEFFEDCBA98};
        for (int i = 0; i < 9; i++) begin
            issue(ta[i], 64'h0, to[i], 5'(i), ok);
            @(negedge clk);
            n_cmp++; if (bus.ack_valid !== 1'b1 || bus.ack_data !== te[i]) begin n_bad++; $display("FAIL extend[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.ack_valid, bus.ack_data, te[i]); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_store;
        bit ok;
        bus.mem_req_retry = 1'b1;
        issue(64'h1004, 64'hCAFEBABE, 4'b1010, 5'd0, ok);
        @(negedge clk);
        n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_we !== 1'b1) begin n_bad++; $display("FAIL st_mem_req got v=%b we=%b exp v=1 we=1", bus.mem_req_valid, bus.mem_req_we); end
        n_cmp++; if (bus.mem_req_addr !== 64'h1004) begin n_bad++; $display("FAIL st_mem_addr got=%h exp=1004", bus.mem_req_addr); end
        n_cmp++; if (bus.mem_req_size !== 2'd2) begin n_bad++; $display("FAIL st_mem_size got=%0d exp=2", bus.mem_req_size); end
        n_cmp++; if (bus.mem_req_data !== 64'hCAFEBABE) begin n_bad++; $display("FAIL st_mem_data got=%h exp=cafebabe", bus.mem_req_data); end
        n_cmp++; if (bus.req_retry !== 1'b1) begin n_bad++; $display("FAIL st_busy_retry got=%b exp=1", bus.req_retry); end
        @(posedge clk);
        #1 bus.mem_req_retry = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h1004) begin n_bad++; $display("FAIL st_hold got v=%b a=%h exp v=1 a=1004", bus.mem_req_valid, bus.mem_req_addr); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (bus.mem_req_valid !== 1'b0 || bus.ack_valid !== 1'b0 || bus.req_retry !== 1'b0) begin n_bad++; $display("FAIL st_done got mv=%b av=%b rr=%b exp 0 0 0", bus.mem_req_valid, bus.ack_valid, bus.req_retry); end
        @(posedge clk);
        #1;
        issue(64'h1004, 64'h0, 4'b0110, 5'd5, ok);
        @(negedge clk);
        n_cmp++; if (bus.ack_valid !== 1'b1 || bus.ack_data !== 64'h00000000CAFEBABE) begin n_bad++; $display("FAIL st_reload got v=%b d=%h exp v=1 d=00000000cafebabe", bus.ack_valid, bus.ack_data); end
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL st_reload_no_fill got=%b exp=0", bus.mem_req_valid); end
        @(posedge clk);
        #1;
        issue(64'h1000, 64'h0, 4'b0011, 5'd5, ok);
        @(negedge clk);
        n_cmp++; if (bus.ack_data !== 64'hCAFEBABE55667788) begin n_bad++; $display("FAIL st_merge got=%h exp=cafebabe55667788", bus.ack_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ack_retry;
        bit ok;
        bus.ack_retry = 1'b1;
        issue(64'h1008, 64'h0, 4'b0011, 5'd3, ok);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.ack_retry = 1'b0;
            @(negedge clk);
            n_cmp++; if (bus.ack_valid !== 1'b1 || bus.ack_data !== 64'h89ABCDEFFEDCBA98 || bus.ack_rd !== 5'd3 || bus.req_retry !== 1'b1) begin n_bad++; $display("FAIL ackhold[%0d] got v=%b d=%h rd=%0d rr=%b exp v=1 d=89abcdeffedcba98 rd=3 rr=1", i, bus.ack_valid, bus.ack_data, bus.ack_rd, bus.req_retry); end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_cmp++; if (bus.ack_valid !== 1'b0 || bus.req_retry !== 1'b0) begin n_bad++; $display("FAIL ackhold_release got v=%b rr=%b exp v=0 rr=0", bus.ack_valid, bus.req_retry); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_misaligned;
        bit ok;
        issue(64'h1002, 64'h0, 4'b0010, 5'd4, ok);
        @(negedge clk);
        n_cmp++; if (bus.ack_valid !== 1'b1 || bus.ack_data !== 64'hDEADDEADDEADDEAD) begin n_bad++; $display("FAIL misld got v=%b d=%h exp v=1 d=deaddeaddeaddead", bus.ack_valid, bus.ack_data); end
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL misld_mem got=%b exp=0", bus.mem_req_valid); end
        @(posedge clk);
        #1;
        issue(64'h1001, 64'hFFFF, 4'b1001, 5'd0, ok);
        @(negedge clk);
        n_cmp++; if (bus.mem_req_valid !== 1'b0 || bus.req_retry !== 1'b0) begin n_bad++; $display("FAIL misst got mv=%b rr=%b exp 0 0", bus.mem_req_valid, bus.req_retry); end
        @(posedge clk);
        #1;
        issue(64'h1000, 64'h0, 4'b0011, 5'd4, ok);
        @(negedge clk);
        n_cmp++; if (bus.ack_data !== 64'hCAFEBABE55667788) begin n_bad++; $display("FAIL misst_nowrite got=%h exp=cafebabe55667788", bus.ack_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stray_ack;
        bit ok;
        bus.mem_ack_valid = 1'b1; bus.mem_ack_data = '0;
        @(posedge clk);
        #1 bus.mem_ack_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.ack_valid !== 1'b0) begin n_bad++; $display("FAIL stray_ack got=%b exp=0", bus.ack_valid); end
        @(posedge clk);
        #1;
        issue(64'h1000, 64'h0, 4'b0011, 5'd2, ok);
        @(negedge clk);
        n_cmp++; if (bus.ack_data !== 64'hCAFEBABE55667788) begin n_bad++; $display("FAIL stray_line got=%h exp=cafebabe55667788", bus.ack_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_fill;
        bit ok, seen, idle;
        issue(64'h2040, 64'h0, 4'b0011, 5'd6, ok);
        @(negedge clk);
        n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h2040) begin n_bad++; $display("FAIL rif_req got v=%b a=%h exp v=1 a=2040", bus.mem_req_valid, bus.mem_req_addr); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rif_wait got=%b exp=0", bus.mem_req_valid); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.ack_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.req_retry !== 1'b1) begin n_bad++; $display("FAIL rif_after got av=%b mv=%b rr=%b exp 0 0 1", bus.ack_valid, bus.mem_req_valid, bus.req_retry); end
        @(posedge clk);
        #1 bus.mem_ack_valid = 1'b1; bus.mem_ack_data = line2;
        @(posedge clk);
        #1 bus.mem_ack_valid = 1'b0;
        seen = 1'b0;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            if (bus.ack_valid) seen = 1'b1;
            idle = !bus.req_retry;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rif_late_ack got=%b exp=0", seen); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL rif_idle_timeout got=%b exp=1", idle); end
        @(posedge clk);
        #1;
        issue(64'h2040, 64'h0, 4'b0011, 5'd6, ok);
        @(negedge clk);
        n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_we !== 1'b0 || bus.ack_valid !== 1'b0) begin n_bad++; $display("FAIL rif_remiss got mv=%b we=%b av=%b exp 1 0 0", bus.mem_req_valid, bus.mem_req_we, bus.ack_valid); end
        @(posedge clk);
        #1 bus.mem_ack_valid = 1'b1; bus.mem_ack_data = line2;
        @(posedge clk);
        #1 bus.mem_ack_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.ack_valid !== 1'b1 || bus.ack_data !== 64'h0BADF00D12345678) begin n_bad++; $display("FAIL rif_refill got v=%b d=%h exp v=1 d=0badf00d12345678", bus.ack_valid, bus.ack_data); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_extend();
        test_store();
        test_ack_retry();
        test_misaligned();
        test_stray_ack();
        test_reset_in_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dcache_param.md
DCACHE_PARAM -- requirements
Module: dcache_param

Interface
REQ-001 SHALL have parameter SETS, default 64, number of direct-mapped lines (power of 2, 4..1024).
REQ-002 SHALL have parameter LINE_BYTES, default 32, line size (power of 2, 8..128).
REQ-003 SHALL have parameter ADDR_W, default 64, address width; TAG_W = ADDR_W - log2(SETS) - log2(LINE_BYTES).
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid / req_retry  in / out  1 / 1  request handshake.
- req_addr  in  ADDR_W  byte address.
- req_data  in  64  store data, LSB-aligned.
- req_op  in  4  [3]=store, [2]=unsigned load, [1:0]=size (0 B, 1 H, 2 W, 3 D).
- req_rd  in  5  load destination register.
- ack_valid / ack_retry  out / in  1 / 1  load-response handshake.
- ack_data  out  64  extended load data.
- ack_rd  out  5  echoed req_rd.
- mem_req_valid / mem_req_retry  out / in  1 / 1  memory-request handshake.
- mem_req_we  out  1  1=write-through store, 0=line fill.
- mem_req_addr  out  ADDR_W  fill: line-aligned; store: byte address.
- mem_req_data  out  64  store data.
- mem_req_size  out  2  store size.
- mem_ack_valid  in  1  fill data valid (single pulse).
- mem_ack_data  in  8*LINE_BYTES  fill line.

Function
REQ-005 SHALL accept a request on a cycle with req_valid=1 and req_retry=0; all other cycles have no effect.
REQ-006 SHALL implement FSM states INIT, IDLE, FILL_REQ, FILL_WAIT, STORE_REQ, RESP.
REQ-007 SHALL, in INIT, clear one valid bit per cycle, indices 0..SETS-1, hold req_retry=1, and enter IDLE after index SETS-1.
REQ-008 SHALL drive req_retry=0 only in IDLE with ack_valid=0.
REQ-009 SHALL, on a load hit in IDLE, assert ack_valid on the next cycle (1-cycle latency) and enter RESP.
REQ-010 SHALL, on a load miss, enter FILL_REQ with mem_req_valid=1, mem_req_we=0, and line-aligned address held stable until mem_req_retry=0, then enter FILL_WAIT.
REQ-011 SHALL, on mem_ack_valid in FILL_WAIT, write the line, tag and valid bit, and assert ack_valid with the selected data on the next cycle (state RESP).
REQ-012 SHALL hold ack_valid, ack_data and ack_rd stable while ack_retry=1 and return to IDLE on the cycle where ack_valid=1 and ack_retry=0.
REQ-013 SHALL sign-extend B/H/W loads when req_op[2]=0 and zero-extend them when req_op[2]=1.
REQ-014 SHALL treat stores as write-through, no-write-allocate: on a hit, merge the written bytes into the line in the accept cycle; on hit or miss, enter STORE_REQ with mem_req_we=1; no ack is produced.
REQ-015 SHALL leave STORE_REQ for IDLE when mem_req_retry=0.
REQ-016 SHALL treat a misaligned access (address not a multiple of size) as follows: a load acks 64'hDEADDEAD_DEADDEAD without a memory access; a store is dropped without a memory access.
REQ-017 SHALL ignore mem_ack_valid outside FILL_WAIT.
REQ-018 SHALL handle only one outstanding request (blocking).

Reset
REQ-019 SHALL, on reset, enter INIT from any state, abandon any in-flight fill or store, and drive ack_valid=0, mem_req_valid=0 and req_retry=1 in the following cycle.
REQ-020 SHALL reset ack_data, ack_rd, mem_req_* data fields and the clear index to 0; line data and tags are not reset.

Configuration
REQ-021 SHALL, with DCACHE_STATS_EN defined, add outputs stat_hits[31:0] and stat_misses[31:0] with these rules: reset to 0, count accepted aligned loads by hit/miss, saturate at 32'hFFFFFFFF, stores not counted.
REQ-022 SHALL, without DCACHE_STATS_EN, have neither the counter ports nor the counter logic.

Verification
REQ-023 SHALL cover reset with SETS=64: req_retry=1 for exactly 64 cycles after reset deasserts, then 0.
REQ-024 SHALL cover a load D @0x1000 (miss) with fill line word0=0x1122334455667788: mem_req addr 0x1000, we=0, and ack_data 0x1122334455667788 one cycle after mem_ack_valid; a repeat load is a hit with ack 1 cycle after accept.
REQ-025 SHALL cover a load B @0x1007 on the same line, req_op=0000: ack_data 0x0000000000000011; with req_op=0100, same value; a byte of 0x88 @0x1000 gives 0xFFFFFFFFFFFFFF88 signed.
REQ-026 SHALL cover a store W 0xCAFEBABE @0x1004 (hit) followed by load W unsigned @0x1004: mem write issued with size=2, and load ack 0x00000000CAFEBABE without a fill.
REQ-027 SHALL cover ack_retry held for 3 cycles on a hit: ack_valid/data stable for 4 cycles and req_retry=1 throughout.
REQ-028 SHALL cover reset asserted in FILL_WAIT followed by a late mem_ack_valid: no ack, the line stays invalid, and the next load to it misses.
